// File: rtl/uart_pkg.sv
// Shared constants and state types for the UART response receiver.
// Holds the status-line match string and both FSM encodings.
package uart_pkg;

    localparam logic [7:0] ASCII_H     = 8'h48;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;

    localparam int MATCH_LEN = 7;
    localparam logic [0:MATCH_LEN-1][7:0] MATCH_STR = "HTTP/1.";

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        P_IDLE,
        P_MATCH,
        P_VER,
        P_SP,
        P_D0,
        P_D1,
        P_D2
    } parse_state_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_0) && (b <= ASCII_9);
    endfunction

    // 'H' is the only start character of the match string, so a
    // mismatching 'H' already counts as the first matched byte.
    function automatic logic [2:0] restart_idx(input logic [7:0] b);
        return (b == ASCII_H) ? 3'd1 : 3'd0;
    endfunction

    function automatic logic [9:0] acc_digit(input logic [9:0] acc,
                                             input logic [7:0] b);
        return 10'(acc * 10'd10 + 10'(b - ASCII_0));
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte deserialiser: rx synchroniser plus bit-timing FSM.
// Samples at bit centres; accepts back-to-back frames with no gap.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    rx_state_t              state;
    logic [CW-1:0]          cnt;
    logic [2:0]             bit_idx;
    logic [7:0]             shift;

    assign rx_s = sync_q[SYNC_STAGES-1];

    // Metastability chain; resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    // Bit-timing FSM with registered byte/error pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        cnt   <= HALF;
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt == '0) begin
                        if (rx_s) begin
                            state <= RX_IDLE;
                        end else begin
                            cnt     <= FULL;
                            bit_idx <= '0;
                            state   <= RX_DATA;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == '0) begin
                        shift <= {rx_s, shift[7:1]};
                        cnt   <= FULL;
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == '0) begin
                        if (rx_s) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= RX_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_response_rx.sv
// UART receive path that hunts for "HTTP/1.x ddd" once armed.
// Reports the 3-digit status code and whether it is a 2xx success.
module uart_response_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       arm,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy,
    output logic [9:0] status_code,
    output logic       status_valid,
    output logic       status_ok
);

    parse_state_t pstate;
    logic [2:0]   idx;
    logic [9:0]   acc;
    logic [9:0]   acc_next;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_byte (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err)
    );

    assign acc_next = acc_digit(acc, rx_data);

    // Status-line parser; arm overrides any byte seen the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pstate       <= P_IDLE;
            idx          <= '0;
            acc          <= '0;
            busy         <= 1'b0;
            status_code  <= '0;
            status_valid <= 1'b0;
            status_ok    <= 1'b0;
        end else begin
            status_valid <= 1'b0;
            if (arm) begin
                pstate <= P_MATCH;
                idx    <= '0;
                acc    <= '0;
                busy   <= 1'b1;
            end else if (frame_err && pstate != P_IDLE) begin
                pstate <= P_MATCH;
                idx    <= '0;
                acc    <= '0;
            end else if (rx_valid) begin
                unique case (pstate)
                    P_IDLE: begin
                    end
                    P_MATCH: begin
                        if (rx_data == MATCH_STR[idx]) begin
                            if (idx == 3'(MATCH_LEN - 1)) begin
                                idx    <= '0;
                                pstate <= P_VER;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else begin
                            idx <= restart_idx(rx_data);
                        end
                    end
                    P_VER: begin
                        if (is_digit(rx_data)) begin
                            pstate <= P_SP;
                        end else begin
                            idx    <= restart_idx(rx_data);
                            pstate <= P_MATCH;
                        end
                    end
                    P_SP: begin
                        if (rx_data == ASCII_SPACE) begin
                            acc    <= '0;
                            pstate <= P_D0;
                        end else begin
                            idx    <= restart_idx(rx_data);
                            pstate <= P_MATCH;
                        end
                    end
                    P_D0, P_D1: begin
                        if (is_digit(rx_data)) begin
                            acc    <= acc_next;
                            pstate <= (pstate == P_D0) ? P_D1 : P_D2;
                        end else begin
                            acc    <= '0;
                            idx    <= restart_idx(rx_data);
                            pstate <= P_MATCH;
                        end
                    end
                    P_D2: begin
                        if (is_digit(rx_data)) begin
                            status_code  <= acc_next;
                            status_ok    <= (acc_next >= 10'd200) &&
                                            (acc_next <= 10'd299);
                            status_valid <= 1'b1;
                            busy         <= 1'b0;
                            acc          <= '0;
                            pstate       <= P_IDLE;
                        end else begin
                            acc    <= '0;
                            idx    <= restart_idx(rx_data);
                            pstate <= P_MATCH;
                        end
                    end
                    default: pstate <= P_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_response_rx.sv
// Directed bench for uart_response_rx with a per-cycle reference model.
// Model searches the armed byte stream for the status-line pattern.
module tb_uart_response_rx;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       arm = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;
    logic [9:0] status_code;
    logic       status_valid;
    logic       status_ok;

    uart_response_rx #(
        .CLKS_PER_BIT(CPB),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .arm         (arm),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_err   (frame_err),
        .busy        (busy),
        .status_code (status_code),
        .status_valid(status_valid),
        .status_ok   (status_ok)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        bit         err;
    } ev_t;

    ev_t        q[$];
    logic [7:0] mbuf[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         cnt_rv = 0;
    int         cnt_fe = 0;
    int         cnt_sv = 0;
    int         rv_cyc = 0;
    int         fall_cyc = 0;

    logic [7:0] m_data = 8'h00;
    logic [9:0] m_code = 10'd0;
    bit         m_ok = 1'b0;
    bit         m_sv = 1'b0;
    bit         m_busy = 1'b0;
    bit         m_armed = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d",
                     nm, got, got, want, want, cyc);
        end
    endtask

    function automatic bit dig(input logic [7:0] b);
        return b >= 8'h30 && b <= 8'h39;
    endfunction

    // Pattern "HTTP/1.<d> <d><d><d>" ending at the newest byte.
    function automatic bit line_found();
        string pat = "HTTP/1.";
        int    n = mbuf.size();
        if (n < 12) return 1'b0;
        for (int i = 0; i < 7; i++)
            if (mbuf[n-12+i] != pat[i]) return 1'b0;
        if (!dig(mbuf[n-5])) return 1'b0;
        if (mbuf[n-4] != 8'h20) return 1'b0;
        for (int i = 1; i <= 3; i++)
            if (!dig(mbuf[n-i])) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int line_code();
        int n = mbuf.size();
        return (int'(mbuf[n-3]) - 48) * 100 +
               (int'(mbuf[n-2]) - 48) * 10 +
               (int'(mbuf[n-1]) - 48);
    endfunction

    // Compare process: check outputs, then advance the model.
    initial begin
        bit         bv;
        bit         fe;
        bit         have;
        ev_t        ev;
        logic [7:0] bd;
        int         c;
        @(posedge clk);
        forever begin
            @(negedge clk);
            bv = 1'b0;
            fe = 1'b0;
            bd = 8'h00;
            if (rx_valid === 1'b1) begin
                cnt_rv++;
                rv_cyc = cyc;
                have = q.size() != 0;
                chk("rx_valid_expected", int'(have), 1);
                if (have) begin
                    ev = q.pop_front();
                    chk("rx_valid_not_err", int'(ev.err), 0);
                    m_data = ev.d;
                    bd = ev.d;
                    bv = 1'b1;
                end
            end
            if (frame_err === 1'b1) begin
                cnt_fe++;
                have = q.size() != 0;
                chk("frame_err_expected", int'(have), 1);
                if (have) begin
                    ev = q.pop_front();
                    chk("frame_err_is_err", int'(ev.err), 1);
                    fe = 1'b1;
                end
            end
            if (status_valid === 1'b1) cnt_sv++;
            chk("rx_data", int'(rx_data), int'(m_data));
            chk("status_valid", int'(status_valid), int'(m_sv));
            chk("status_code", int'(status_code), int'(m_code));
            chk("status_ok", int'(status_ok), int'(m_ok));
            chk("busy", int'(busy), int'(m_busy));
            m_sv = 1'b0;
            if (!reset) begin
                m_data = 8'h00;
                m_code = 10'd0;
                m_ok = 1'b0;
                m_busy = 1'b0;
                m_armed = 1'b0;
                mbuf.delete();
            end else if (arm) begin
                m_armed = 1'b1;
                m_busy = 1'b1;
                mbuf.delete();
            end else if (fe) begin
                mbuf.delete();
            end else if (bv && m_armed) begin
                mbuf.push_back(bd);
                if (line_found()) begin
                    c = line_code();
                    m_code = 10'(c);
                    m_ok = (c >= 200 && c <= 299);
                    m_sv = 1'b1;
                    m_busy = 1'b0;
                    m_armed = 1'b0;
                end
            end
        end
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        ev_t e;
        e.d = d;
        e.err = !stop;
        q.push_back(e);
        fall_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
        rx = 1'b1;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic pulse_arm();
        @(posedge clk);
        #1 arm = 1'b1;
        @(posedge clk);
        #1 arm = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        idle(4);
        chk("reset_busy", int'(busy), 0);
        chk("reset_status_code", int'(status_code), 0);
        reset = 1'b1;
        idle(3);

        pulse_arm();
        cnt_rv = 0;
        cnt_fe = 0;
        send_byte(8'hA5, 1'b1);
        idle(3);
        lat = rv_cyc - fall_cyc;
        chk("a5_latency_in_78_80", int'(lat >= 78 && lat <= 80), 1);
        chk("a5_rx_data", int'(rx_data), 8'hA5);
        chk("a5_rx_valid_count", cnt_rv, 1);
        chk("a5_frame_err_count", cnt_fe, 0);

        pulse_arm();
        cnt_sv = 0;
        send_str("xxHTTP/1.1 200 OK\r\n");
        idle(5);
        chk("200_sv_count", cnt_sv, 1);
        chk("200_code", int'(status_code), 200);
        chk("200_ok", int'(status_ok), 1);
        chk("200_busy_low", int'(busy), 0);
        pulse_arm();
        idle(1);
        chk("rearm_busy_high", int'(busy), 1);

        cnt_sv = 0;
        send_str("HTTHTTP/1.0 404");
        idle(5);
        chk("404_sv_count", cnt_sv, 1);
        chk("404_code", int'(status_code), 404);
        chk("404_ok", int'(status_ok), 0);

        pulse_arm();
        cnt_sv = 0;
        send_str("HTTP/1.1 2x0");
        idle(5);
        chk("2x0_no_status", cnt_sv, 0);
        send_str("HTTP/1.1 503");
        idle(5);
        chk("503_sv_count", cnt_sv, 1);
        chk("503_code", int'(status_code), 503);
        chk("503_ok", int'(status_ok), 0);

        cnt_rv = 0;
        cnt_fe = 0;
        send_byte(8'h48, 1'b0);
        idle(20);
        chk("ferr_count", cnt_fe, 1);
        chk("ferr_no_rx_valid", cnt_rv, 0);
        chk("ferr_rx_data_kept", int'(rx_data), 8'h33);

        cnt_rv = 0;
        cnt_fe = 0;
        rx = 1'b0;
        idle(1);
        rx = 1'b1;
        idle(40);
        chk("glitch_no_rx_valid", cnt_rv, 0);
        chk("glitch_no_frame_err", cnt_fe, 0);

        pulse_arm();
        cnt_sv = 0;
        send_str("HTTP/1.1 2");
        idle(3);
        reset = 1'b0;
        idle(3);
        reset = 1'b1;
        idle(2);
        send_str("00");
        idle(5);
        chk("rst_no_status", cnt_sv, 0);
        chk("rst_busy_low", int'(busy), 0);
        pulse_arm();
        send_str("HTTP/1.1 201");
        idle(5);
        chk("201_sv_count", cnt_sv, 1);
        chk("201_code", int'(status_code), 201);
        chk("201_ok", int'(status_ok), 1);

        idle(10);
        chk("all_bytes_delivered", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_response_rx.md
Name: uart_response_rx

Overview:
- Receive side of the UART link used by the request-transmit path.
- Deserialises 8N1 bytes from the rx pin and scans the byte stream for an HTTP status line ("HTTP/1.x ddd").
- Reports the decoded 3-digit status code so the controller can decide whether the POST succeeded.
- Runs on CLOCK_50 with an internal bit-timing counter. It is armed by the transmit side when a request finishes.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200). Minimum 4.
- SYNC_STAGES, 2, rx metastability synchroniser depth.

Ports:
- clk  input  1  system clock (CLOCK_50)
- reset  input  1  synchronous, active-low reset
- rx  input  1  asynchronous serial input; idle high
- arm  input  1  one-cycle pulse; starts or restarts the status-line search
- rx_data  output  8  last received byte
- rx_valid  output  1  one-cycle pulse; rx_data holds a new good byte
- frame_err  output  1  one-cycle pulse; stop bit sampled low
- busy  output  1  high while armed and the status line is not yet decoded
- status_code  output  10  binary status value, 0..999
- status_valid  output  1  one-cycle pulse when status_code updates
- status_ok  output  1  registered; status_code in 200..299 (held with status_code)

Behaviour:
- Reset (reset==0 at clk edge) clears all of the following:
  - rx_data=0, rx_valid=0, frame_err=0, busy=0.
  - status_code=0, status_valid=0, status_ok=0.
  - Both FSMs go to IDLE. Synchroniser flops are set to 1.
  - Reset mid-byte or mid-status-line discards all partial state.
- Byte receiver FSM: IDLE, START, DATA, STOP.
  - IDLE: wait for the synchronised rx to go low. Load the counter with CLKS_PER_BIT/2 - 1 (integer division) and go to START.
  - START: at counter expiry, re-sample rx. If rx is high, treat it as a glitch and return to IDLE with no output. If rx is low, go to DATA.
  - DATA: sample 8 bits LSB-first, one every CLKS_PER_BIT cycles, at bit centre. Use a 3-bit bit index.
  - STOP: sample one CLKS_PER_BIT later.
    - If rx is high: update rx_data and pulse rx_valid on the next cycle.
    - If rx is low: pulse frame_err. rx_data is unchanged and no rx_valid is issued.
  - From STOP, return to IDLE on the same edge as the sample. A back-to-back start bit is therefore accepted with no gap.
  - Latency: rx_valid rises 1 cycle after the stop-bit centre sample, plus SYNC_STAGES cycles of input delay.
- Parser FSM: IDLE, MATCH, VER, SP, D0, D1, D2. It consumes bytes only on rx_valid.
  - IDLE: ignores bytes.
  - arm in any state: go to MATCH with match index 0 and assert busy. Any partial code is dropped.
  - MATCH: compare the byte with "HTTP/1."[idx].
    - Equal: idx++. After idx 6 matches, go to VER.
    - Not equal: if the byte is 'H', set idx=1; otherwise set idx=0. Stay in MATCH.
  - VER: any byte '0'..'9' goes to SP. A non-digit goes to MATCH with the 'H' recheck applied.
  - SP: 0x20 goes to D0. Anything else goes to MATCH with the 'H' recheck applied.
  - D0, D1, D2: only digits '0'..'9' are accepted. A non-digit goes to MATCH with the 'H' recheck applied.
    - Accumulate acc = acc*10 + (byte-0x30). The accumulator is 10 bits; the maximum value 999 fits.
  - Leaving D2 with a digit:
    - Next cycle: status_code=acc, status_ok=(acc>=200 && acc<=299), status_valid pulses, busy drops.
    - Then go to IDLE.
  - Bytes after the 3rd digit are not checked.
  - frame_err while in MATCH..D2: go to MATCH with idx=0; the accumulator is discarded.
  - arm on the same cycle as rx_valid: arm wins and the byte is dropped.
- status_code and status_ok hold their values until the next status_valid or reset.

Decomposition:
- Shared package uart_pkg:
  - Byte constants: ASCII_H, ASCII_SPACE, ASCII_0, ASCII_9.
  - The 7-byte "HTTP/1." match string, as a localparam array.
  - rx_state_t and parse_state_t enums.
- One sub-module, uart_rx_byte:
  - Contains the synchroniser and the bit-timing FSM.
  - Outputs rx_data, rx_valid and frame_err.
- The top level instantiates uart_rx_byte and holds the parser FSM.

Test Plan:
- Bench parameters: CLKS_PER_BIT=8. Send byte 0xA5 after arm.
  - Required: rx_valid is a single pulse, rx_data=0xA5, no frame_err.
  - Required: rx_valid occurs at 8*9+4+2+1 = 79 ±1 cycles after the start-bit falling edge.
- Arm, then send "xxHTTP/1.1 200 OK\r\n".
  - Required: status_valid pulses once, status_code=200, status_ok=1, busy falls.
  - Required: a later arm re-raises busy.
- Send "HTTHTTP/1.0 404".
  - Required: the restart via the 'H' recheck succeeds; status_code=404, status_ok=0.
- Send "HTTP/1.1 2x0", then "HTTP/1.1 503".
  - Required: no status_valid after the first string; the second gives status_code=503, status_ok=0.
- Send byte 0x48 with the stop bit forced low.
  - Required: frame_err pulses, rx_valid stays 0, rx_data is unchanged.
  - Required: a 1-cycle low glitch while rx is idle produces no output.
- Assert reset mid-way through "HTTP/1.1 2", then release it and send "00".
  - Required: no status_valid and busy=0.
  - Then arm and send the full "HTTP/1.1 201". Required: status_code=201.
